// File: rtl/load_store_unit_if.sv
// Request, data-memory and response signals of the load/store unit.
// Signal names keep their _i/_o suffixes as seen from the LSU.
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]           req_wdata_i;
    logic [4:0]            req_rd_i;

    logic                  dmem_valid_o;
    logic                  dmem_ready_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_o;
    logic [31:0]           dmem_wdata_o;
    logic [3:0]            dmem_we_o;
    logic [31:0]           dmem_rdata_i;

    logic                  rsp_valid_o;
    logic                  rsp_we_o;
    logic [4:0]            rsp_rd_o;
    logic [31:0]           rsp_rdata_o;
    logic                  misalign_o;

    // LSU side
    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
               req_wdata_i, req_rd_i, dmem_ready_i, dmem_rdata_i,
        output req_ready_o, dmem_valid_o, dmem_addr_o, dmem_wdata_o, dmem_we_o,
               rsp_valid_o, rsp_we_o, rsp_rd_o, rsp_rdata_o, misalign_o
    );

    // Execute stage / memory side
    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
               req_wdata_i, req_rd_i, dmem_ready_i, dmem_rdata_i,
        input  req_ready_o, dmem_valid_o, dmem_addr_o, dmem_wdata_o, dmem_we_o,
               rsp_valid_o, rsp_we_o, rsp_rd_o, rsp_rdata_o, misalign_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access, IDLE -> BUSY -> RESP -> IDLE.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no memory access, response with misalign_o = 1).
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    load_store_unit_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  dvalid_q, dvalid_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [31:0]           dwdata_q, dwdata_d;
    logic [3:0]            dbe_q, dbe_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rwe_q, rwe_d;
    logic [4:0]            rrd_q, rrd_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mis_q, mis_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [4:0]            rd_q, rd_d;

    logic                  mis_c;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           ld_ext;

    // Misalignment detect on the incoming request
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_c = ((bus.req_size_i == 2'b01) && bus.req_addr_i[0]) ||
                   (bus.req_size_i[1] && (bus.req_addr_i[1:0] != 2'b00));
`else
    assign mis_c = 1'b0;
`endif

    // Lane select and sign/zero extension of the returned memory word
    always_comb begin
        lane_b = 8'h00;
        case (off_q)
            2'd0:    lane_b = bus.dmem_rdata_i[7:0];
            2'd1:    lane_b = bus.dmem_rdata_i[15:8];
            2'd2:    lane_b = bus.dmem_rdata_i[23:16];
            default: lane_b = bus.dmem_rdata_i[31:24];
        endcase
        lane_h = off_q[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   ld_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ld_ext = bus.dmem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        dvalid_d = dvalid_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dbe_d    = dbe_q;
        rvalid_d = 1'b0;
        rwe_d    = 1'b0;
        rrd_d    = rrd_q;
        rdata_d  = rdata_q;
        mis_d    = 1'b0;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    size_d  = bus.req_size_i;
                    uns_d   = bus.req_unsigned_i;
                    off_d   = bus.req_addr_i[1:0];
                    rd_d    = bus.req_rd_i;
                    daddr_d = {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    case (bus.req_size_i)
                        2'b00: begin
                            dwdata_d = {4{bus.req_wdata_i[7:0]}};
                            dbe_d    = 4'b0001 << bus.req_addr_i[1:0];
                        end
                        2'b01: begin
                            dwdata_d = {2{bus.req_wdata_i[15:0]}};
                            dbe_d    = 4'b0011 << {bus.req_addr_i[1], 1'b0};
                        end
                        default: begin
                            dwdata_d = bus.req_wdata_i;
                            dbe_d    = 4'b1111;
                        end
                    endcase
                    if (!bus.req_we_i) begin
                        dbe_d = 4'b0000;
                    end
                    if (mis_c) begin
                        // Trap: skip the memory access entirely
                        state_d  = RESP;
                        dvalid_d = 1'b0;
                        rvalid_d = 1'b1;
                        mis_d    = 1'b1;
                        rrd_d    = bus.req_rd_i;
                        rdata_d  = 32'h0;
                    end else begin
                        state_d  = BUSY;
                        dvalid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus.dmem_ready_i) begin
                    state_d  = RESP;
                    dvalid_d = 1'b0;
                    rvalid_d = 1'b1;
                    rwe_d    = !we_q && (rd_q != 5'd0);
                    rrd_d    = rd_q;
                    rdata_d  = we_q ? 32'h0 : ld_ext;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            dvalid_q <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= 32'h0;
            dbe_q    <= 4'h0;
            rvalid_q <= 1'b0;
            rwe_q    <= 1'b0;
            rrd_q    <= 5'd0;
            rdata_q  <= 32'h0;
            mis_q    <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            rd_q     <= 5'd0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            dvalid_q <= dvalid_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dbe_q    <= dbe_d;
            rvalid_q <= rvalid_d;
            rwe_q    <= rwe_d;
            rrd_q    <= rrd_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.req_ready_o  = ready_q;
    assign bus.dmem_valid_o = dvalid_q;
    assign bus.dmem_addr_o  = daddr_q;
    assign bus.dmem_wdata_o = dwdata_q;
    assign bus.dmem_we_o    = dbe_q;
    assign bus.rsp_valid_o  = rvalid_q;
    assign bus.rsp_we_o     = rwe_q;
    assign bus.rsp_rd_o     = rrd_q;
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.misalign_o   = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit (honours LSU_MISALIGN_TRAP_EN).
module tb_load_store_unit;
    logic clk;
    logic rst_n;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] mem;
        int          waits;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rwe;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_dmem(input vec_t v, input string tag);
        chk({v.name, tag, " dvalid"}, 32'(bus.dmem_valid_o), 32'd1);
        chk({v.name, tag, " daddr"},  bus.dmem_addr_o, v.e_addr);
        chk({v.name, tag, " dbe"},    32'(bus.dmem_we_o), 32'(v.e_be));
        if (v.we) chk({v.name, tag, " dwdata"}, bus.dmem_wdata_o, v.e_wdata);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = v.we;
        bus.req_size_i     = v.size;
        bus.req_unsigned_i = v.uns;
        bus.req_addr_i     = v.addr;
        bus.req_wdata_i    = v.wdata;
        bus.req_rd_i       = v.rd;
        bus.dmem_rdata_i   = v.mem;
        bus.dmem_ready_i   = 1'b0;
        chk({v.name, " ready before"}, 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk_dmem(v, " T+1");
        chk({v.name, " busy ready"}, 32'(bus.req_ready_o), 32'd0);
        for (int i = 0; i < v.waits; i++) begin
            // Junk request while busy must be ignored
            bus.req_valid_i = 1'b1;
            bus.req_addr_i  = 32'hFFFF_FFF0;
            bus.req_wdata_i = 32'h5555_5555;
            @(negedge clk);
            chk_dmem(v, " wait");
            chk({v.name, " no rsp in wait"}, 32'(bus.rsp_valid_o), 32'd0);
        end
        bus.req_valid_i  = 1'b0;
        bus.dmem_ready_i = 1'b1;
        @(negedge clk);
        bus.dmem_ready_i = 1'b0;
        chk({v.name, " rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        chk({v.name, " dvalid drop"}, 32'(bus.dmem_valid_o), 32'd0);
        chk({v.name, " rsp_we"}, 32'(bus.rsp_we_o), 32'(v.e_rwe));
        chk({v.name, " rsp_rd"}, 32'(bus.rsp_rd_o), 32'(v.rd));
        chk({v.name, " rsp_rdata"}, bus.rsp_rdata_o, v.e_rdata);
        chk({v.name, " misalign"}, 32'(bus.misalign_o), 32'd0);
        @(negedge clk);
        chk({v.name, " rsp one cycle"}, 32'(bus.rsp_valid_o), 32'd0);
        chk({v.name, " ready T+3"}, 32'(bus.req_ready_o), 32'd1);
    endtask

    initial begin
        bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_size_i = 0; bus.req_unsigned_i = 0;
        bus.req_addr_i = 0; bus.req_wdata_i = 0; bus.req_rd_i = 0;
        bus.dmem_ready_i = 0; bus.dmem_rdata_i = 0;
        rst_n = 1'b0;

        //           name     we size uns addr          wdata         rd   mem           w  e_addr        e_be     e_wdata       rwe e_rdata
        vecs.push_back('{"LB103",  0, 2'b00, 0, 32'h103, 32'h0,        5,  32'h80FF_1234, 0, 32'h100, 4'b0000, 32'h0,        1, 32'hFFFF_FF80});
        vecs.push_back('{"LHU202", 0, 2'b01, 1, 32'h202, 32'h0,        6,  32'hBEEF_0000, 0, 32'h200, 4'b0000, 32'h0,        1, 32'h0000_BEEF});
        vecs.push_back('{"LH202",  0, 2'b01, 0, 32'h202, 32'h0,        7,  32'hBEEF_0000, 0, 32'h200, 4'b0000, 32'h0,        1, 32'hFFFF_BEEF});
        vecs.push_back('{"SB01",   1, 2'b00, 0, 32'h01,  32'h0000_00AB, 3, 32'h0,         3, 32'h0,   4'b0010, 32'hABAB_ABAB, 0, 32'h0});
        vecs.push_back('{"LWrd0",  0, 2'b10, 0, 32'h10,  32'h0,        0,  32'h1234_5678, 0, 32'h10,  4'b0000, 32'h0,        0, 32'h1234_5678});
        vecs.push_back('{"SH12",   1, 2'b01, 0, 32'h12,  32'h1234_CAFE, 2, 32'h0,         0, 32'h10,  4'b1100, 32'hCAFE_CAFE, 0, 32'h0});
        vecs.push_back('{"SW20",   1, 2'b10, 0, 32'h20,  32'hDEAD_BEEF, 1, 32'h0,         1, 32'h20,  4'b1111, 32'hDEAD_BEEF, 0, 32'h0});
        vecs.push_back('{"LBU02",  0, 2'b00, 1, 32'h02,  32'h0,        9,  32'h00A5_0000, 0, 32'h0,   4'b0000, 32'h0,        1, 32'h0000_00A5});
        vecs.push_back('{"LB00",   0, 2'b00, 0, 32'h00,  32'h0,        10, 32'h0000_007F, 0, 32'h0,   4'b0000, 32'h0,        1, 32'h0000_007F});
        vecs.push_back('{"LSz3",   0, 2'b11, 0, 32'h30,  32'h0,        11, 32'hCAFE_BABE, 2, 32'h30,  4'b0000, 32'h0,        1, 32'hCAFE_BABE});
`ifndef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{"LW06",   0, 2'b10, 0, 32'h06,  32'h0,        12, 32'h1122_3344, 0, 32'h04,  4'b0000, 32'h0,        1, 32'h1122_3344});
        vecs.push_back('{"SW06",   1, 2'b10, 0, 32'h06,  32'h1122_3344, 1, 32'h0,         0, 32'h04,  4'b1111, 32'h1122_3344, 0, 32'h0});
        vecs.push_back('{"SH03",   1, 2'b01, 0, 32'h03,  32'h0000_BEEF, 1, 32'h0,         0, 32'h0,   4'b1100, 32'hBEEF_BEEF, 0, 32'h0});
`endif

        // Reset state
        #12;
        chk("rst ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst dvalid", 32'(bus.dmem_valid_o), 32'd0);
        chk("rst dbe", 32'(bus.dmem_we_o), 32'd0);
        chk("rst daddr", bus.dmem_addr_o, 32'h0);
        chk("rst dwdata", bus.dmem_wdata_o, 32'h0);
        chk("rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst rsp_we", 32'(bus.rsp_we_o), 32'd0);
        chk("rst rsp_rd", 32'(bus.rsp_rd_o), 32'd0);
        chk("rst rsp_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rst misalign", 32'(bus.misalign_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during BUSY abandons the access
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'b10;
        bus.req_addr_i = 32'h40; bus.req_rd_i = 5'd3; bus.dmem_ready_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("rstmid dvalid before", 32'(bus.dmem_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid dvalid async", 32'(bus.dmem_valid_o), 32'd0);
        chk("rstmid ready async", 32'(bus.req_ready_o), 32'd1);
        bus.dmem_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid no rsp", 32'(bus.rsp_valid_o), 32'd0);
            chk("rstmid no dvalid", 32'(bus.dmem_valid_o), 32'd0);
            chk("rstmid ready", 32'(bus.req_ready_o), 32'd1);
        end
        bus.dmem_ready_i = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned word load traps without touching memory
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'b10;
        bus.req_addr_i = 32'h06; bus.req_rd_i = 5'd7; bus.dmem_ready_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("mis dvalid", 32'(bus.dmem_valid_o), 32'd0);
        chk("mis rsp_valid T+1", 32'(bus.rsp_valid_o), 32'd1);
        chk("mis flag", 32'(bus.misalign_o), 32'd1);
        chk("mis rsp_we", 32'(bus.rsp_we_o), 32'd0);
        chk("mis rsp_rd", 32'(bus.rsp_rd_o), 32'd7);
        @(negedge clk);
        chk("mis rsp one cycle", 32'(bus.rsp_valid_o), 32'd0);
        chk("mis ready", 32'(bus.req_ready_o), 32'd1);
        chk("mis no dvalid", 32'(bus.dmem_valid_o), 32'd0);
        bus.dmem_ready_i = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
